// File: rtl/tnn_neuron_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tnn_sched_pkg
// Description : Shared types and helpers for the TNN neuron scheduler.
//               FEAT_W / NUM_SLOTS  - feature width and operands per neuron
//               feat_t              - one 3-bit unsigned feature
//               sched_state_e       - scheduler FSM states
//               default_idx()       - reset contents of the index table
// Revision    : 1.0 - initial release
// ============================================================================
package tnn_sched_pkg;

  localparam int FEAT_W    = 3;
  localparam int NUM_SLOTS = 6;

  typedef logic [FEAT_W-1:0] feat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  // Entry (n,s) of the index table after reset.
  function automatic int default_idx(input int n, input int s, input int num_feat);
    return (n + s) % num_feat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tnn_neuron_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface   : tnn_neuron_scheduler_if
// Description : Sample-in / layer-out stream handshakes of the scheduler.
//               in_valid/in_ready/in_feat    - feature vector (feature i at
//                                              bits [3i+2:3i])
//               out_valid/out_ready/out_bits - layer decision vector
//               master : upstream producer / downstream consumer side
//               slave  : scheduler side
// Revision    : 1.0 - initial release
// ============================================================================
interface tnn_neuron_scheduler_if #(
  parameter int NUM_FEAT    = 11,
  parameter int NUM_NEURONS = 8
) ();
  import tnn_sched_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_FEAT*FEAT_W-1:0] in_feat;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_NEURONS-1:0]     out_bits;

  modport master (
    output in_valid, in_feat, out_ready,
    input  in_ready, out_valid, out_bits
  );

  modport slave (
    input  in_valid, in_feat, out_ready,
    output in_ready, out_valid, out_bits
  );

endinterface
`default_nettype wire

// File: rtl/tnn_neuron_scheduler_cfg_table.sv
`default_nettype none
// ============================================================================
// Module      : tnn_sched_cfg_table
// Description : Register-file index table, NUM_NEURONS x NUM_SLOTS entries.
//               i_we/i_neuron/i_slot/i_idx - write port; applied only when
//                                            i_en is high and the address and
//                                            data are in range
//               i_rd_neuron                - read neuron select
//               o_rd_idx[s]                - combinational index of slot s
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_sched_cfg_table
  import tnn_sched_pkg::*;
#(
  parameter int NUM_FEAT    = 11,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_FEAT),
  parameter int NRN_W       = $clog2(NUM_NEURONS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_we,
  input  logic                              i_en,
  input  logic [NRN_W-1:0]                  i_neuron,
  input  logic [2:0]                        i_slot,
  input  logic [IDX_W-1:0]                  i_idx,
  input  logic [NRN_W-1:0]                  i_rd_neuron,
  output logic [NUM_SLOTS-1:0][IDX_W-1:0]   o_rd_idx
);

  logic [IDX_W-1:0] r_tbl [NUM_NEURONS][NUM_SLOTS];
  logic             w_wr_ok;

  // Extra MSB on the compares keeps them correct when a count is a power of two.
  assign w_wr_ok = i_we && i_en
                && ({1'b0, i_neuron} < (NRN_W+1)'(NUM_NEURONS))
                && (i_slot < 3'(NUM_SLOTS))
                && ({1'b0, i_idx} < (IDX_W+1)'(NUM_FEAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          r_tbl[n][s] <= IDX_W'(default_idx(n, s, NUM_FEAT));
        end
      end
    end else if (w_wr_ok) begin
      r_tbl[i_neuron][i_slot] <= i_idx;
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_rd
    assign o_rd_idx[s] = r_tbl[i_rd_neuron][s];
  end

endmodule
`default_nettype wire

// File: rtl/tnn_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tnn_neuron_scheduler
// Description : Time-multiplexes one shared 6-input TNN neuron over
//               NUM_NEURONS logical neurons. One sample is accepted, each
//               neuron's six operands are routed from the index table to the
//               registered nrn_* ports, and the 1-bit decisions are gathered
//               into the layer output vector.
//   clk, rst_n        - clock, asynchronous active-low reset
//   bus (slave)       - in_valid/in_ready/in_feat, out_valid/out_ready/out_bits
//   i_cfg_we/_neuron/_slot/_idx - index-table write port (IDLE only)
//   o_cfg_busy        - high whenever the FSM is not IDLE
//   o_nrn_a..o_nrn_f  - registered operands to the shared neuron
//   i_nrn_out         - combinational decision of the shared neuron
// Revision    : 1.0 - initial release
// ============================================================================
module tnn_neuron_scheduler
  import tnn_sched_pkg::*;
#(
  parameter int NUM_FEAT    = 11,
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = $clog2(NUM_FEAT),
  parameter int NRN_W       = $clog2(NUM_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tnn_neuron_scheduler_if.slave bus,
  input  logic                 i_cfg_we,
  input  logic [NRN_W-1:0]     i_cfg_neuron,
  input  logic [2:0]           i_cfg_slot,
  input  logic [IDX_W-1:0]     i_cfg_idx,
  output logic                 o_cfg_busy,
  output feat_t                o_nrn_a,
  output feat_t                o_nrn_b,
  output feat_t                o_nrn_c,
  output feat_t                o_nrn_d,
  output feat_t                o_nrn_e,
  output feat_t                o_nrn_f,
  input  logic                 i_nrn_out
);

  localparam int CNT_W = $clog2(NUM_NEURONS + 1);

  sched_state_e                     r_state;
  sched_state_e                     w_state_nxt;
  logic [CNT_W-1:0]                 r_cnt;
  feat_t [NUM_FEAT-1:0]             r_feat;
  feat_t                            r_nrn [NUM_SLOTS];
  logic [NUM_NEURONS-1:0]           r_out_bits;

  logic                             w_in_ready;
  logic                             w_out_valid;
  logic                             w_busy;
  logic                             w_cnt_live;
  logic [NRN_W-1:0]                 w_cap_idx;
  logic [NUM_SLOTS-1:0][IDX_W-1:0]  w_tbl_idx;
  feat_t                            w_sel [NUM_SLOTS];

  // --------------------------------------------------------------------------
  // Index table; reads follow the neuron counter, writes only land in IDLE.
  // --------------------------------------------------------------------------
  tnn_sched_cfg_table #(
    .NUM_FEAT    (NUM_FEAT),
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .NRN_W       (NRN_W)
  ) u_cfg_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_we        (i_cfg_we),
    .i_en        (r_state == IDLE),
    .i_neuron    (i_cfg_neuron),
    .i_slot      (i_cfg_slot),
    .i_idx       (i_cfg_idx),
    .i_rd_neuron (r_cnt[NRN_W-1:0]),
    .o_rd_idx    (w_tbl_idx)
  );

  // Table contents are range-checked on write; the guard only protects the
  // mux against indices that can never be stored.
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_sel
    assign w_sel[s] = ({1'b0, w_tbl_idx[s]} < (IDX_W+1)'(NUM_FEAT))
                    ? r_feat[w_tbl_idx[s]] : '0;
  end

  assign w_cnt_live = (r_cnt < CNT_W'(NUM_NEURONS));
  // Decision arriving now belongs to the neuron whose operands were loaded
  // on the previous cycle.
  assign w_cap_idx  = NRN_W'(r_cnt - 1'b1);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(NUM_NEURONS)) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_feat     <= '0;
      r_out_bits <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_nrn[s] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_feat     <= bus.in_feat;
            r_cnt      <= '0;
            r_out_bits <= '0;
          end
        end
        RUN: begin
          if (w_cnt_live) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
              r_nrn[s] <= w_sel[s];
            end
            r_cnt <= r_cnt + 1'b1;
          end
          if (r_cnt != '0) begin
            r_out_bits[w_cap_idx] <= i_nrn_out;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_bits  = r_out_bits;
  assign o_cfg_busy    = w_busy;

  assign o_nrn_a = r_nrn[0];
  assign o_nrn_b = r_nrn[1];
  assign o_nrn_c = r_nrn[2];
  assign o_nrn_d = r_nrn[3];
  assign o_nrn_e = r_nrn[4];
  assign o_nrn_f = r_nrn[5];

endmodule
`default_nettype wire

// File: tb/tb_tnn_neuron_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tnn_neuron_scheduler
// Description : Self-checking bench for tnn_neuron_scheduler. The shared
//               neuron is stubbed as nrn_out = nrn_a[2]; the reference model
//               keeps its own copy of the index table and evaluates the layer
//               directly from the feature vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tnn_neuron_scheduler;
  import tnn_sched_pkg::*;

  localparam int NF = 11;
  localparam int NN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tnn_neuron_scheduler_if #(.NUM_FEAT(NF), .NUM_NEURONS(NN)) bus ();

  logic       cfg_we = 1'b0;
  logic [2:0] cfg_neuron = '0;
  logic [2:0] cfg_slot = '0;
  logic [3:0] cfg_idx = '0;
  logic       cfg_busy;
  feat_t      na, nb, nc, nd, ne, nf;
  logic       nrn_out;

  assign nrn_out = na[2];

  tnn_neuron_scheduler #(.NUM_FEAT(NF), .NUM_NEURONS(NN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_cfg_we     (cfg_we),
    .i_cfg_neuron (cfg_neuron),
    .i_cfg_slot   (cfg_slot),
    .i_cfg_idx    (cfg_idx),
    .o_cfg_busy   (cfg_busy),
    .o_nrn_a      (na),
    .o_nrn_b      (nb),
    .o_nrn_c      (nc),
    .o_nrn_d      (nd),
    .o_nrn_e      (ne),
    .o_nrn_f      (nf),
    .i_nrn_out    (nrn_out)
  );

  // ---------------- handshake monitors ----------------
  int          cyc = 0;
  int          hs_q[$];
  logic [7:0]  out_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.in_valid && bus.in_ready) hs_q.push_back(cyc);
    if (rst_n && bus.out_valid && bus.out_ready) out_q.push_back(bus.out_bits);
  end

  // ---------------- reference model ----------------
  int m_tbl [NN][6];

  function automatic void model_reset();
    for (int n = 0; n < NN; n++)
      for (int s = 0; s < 6; s++)
        m_tbl[n][s] = (n + s) % NF;
  endfunction

  function automatic void model_write(input int n, input int s, input int idx);
    if (s <= 5 && idx < NF) m_tbl[n][s] = idx;
  endfunction

  // Neuron n fires when its slot-a feature has its MSB set (value >= 4).
  function automatic logic [7:0] model_out(input logic [32:0] f);
    logic [7:0] r;
    int v;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      v = int'(f[3*m_tbl[n][0] +: 3]);
      r[n] = (v >= 4);
    end
    return r;
  endfunction

  function automatic logic [32:0] feat_default();
    logic [32:0] f;
    for (int i = 0; i < NF; i++) f[3*i +: 3] = 3'(i % 8);
    return f;
  endfunction

  function automatic logic [32:0] feat_rand();
    logic [32:0] f;
    for (int i = 0; i < NF; i++) f[3*i +: 3] = 3'($urandom_range(7, 0));
    return f;
  endfunction

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_write(input logic [2:0] n, input logic [2:0] s, input logic [3:0] idx);
    check("busy idle", cfg_busy, 0);
    cfg_we = 1'b1; cfg_neuron = n; cfg_slot = s; cfg_idx = idx;
    step();
    cfg_we = 1'b0;
    model_write(n, s, idx);
  endtask

  // Counts cycles from t0 until out_valid; t is the cycle index relative to T0.
  task automatic wait_valid(input int t0, output int t);
    t = t0;
    while (!bus.out_valid && t < 40) begin
      step();
      t++;
    end
  endtask

  task automatic start_sample(input logic [32:0] f);
    bus.in_valid = 1'b1;
    bus.in_feat  = f;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [32:0] f, input bit wr, input logic [2:0] n,
                         input logic [2:0] s, input logic [3:0] idx,
                         input logic [7:0] exp, input string name);
    int t;
    check({name, " in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_feat  = f;
    if (wr) begin
      cfg_we = 1'b1; cfg_neuron = n; cfg_slot = s; cfg_idx = idx;
    end
    step();
    bus.in_valid = 1'b0;
    cfg_we = 1'b0;
    wait_valid(1, t);
    check({name, " latency"}, t, 10);
    check({name, " bits"}, bus.out_bits, exp);
    step();
    check({name, " in_ready T11"}, bus.in_ready, 1);
    check({name, " out_valid T11"}, bus.out_valid, 0);
  endtask

  typedef struct {
    int         kind;   // 0 none, 1 write in IDLE before sample, 2 write with handshake
    logic [2:0] n;
    logic [2:0] s;
    logic [3:0] idx;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int t;
    int base_hs, base_out, cnt_v;
    logic [32:0] fdef, f2;
    logic [32:0] fb [4];
    logic [7:0]  e2;

    vecs[0]  = '{0, 3'd0, 3'd0, 4'd0,  8'hF0};
    vecs[1]  = '{1, 3'd0, 3'd0, 4'd11, 8'hF0};
    vecs[2]  = '{1, 3'd0, 3'd6, 4'd7,  8'hF0};
    vecs[3]  = '{1, 3'd0, 3'd0, 4'd7,  8'hF1};
    vecs[4]  = '{1, 3'd0, 3'd0, 4'd0,  8'hF0};
    vecs[5]  = '{1, 3'd5, 3'd0, 4'd0,  8'hD0};
    vecs[6]  = '{1, 3'd5, 3'd1, 4'd0,  8'hD0};
    vecs[7]  = '{1, 3'd3, 3'd0, 4'd6,  8'hD8};
    vecs[8]  = '{1, 3'd7, 3'd0, 4'd8,  8'h58};
    vecs[9]  = '{2, 3'd1, 3'd0, 4'd4,  8'h5A};
    vecs[10] = '{2, 3'd2, 3'd0, 4'd15, 8'h5A};

    fdef = feat_default();
    bus.in_valid  = 1'b0;
    bus.in_feat   = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // ---- reset state ----
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_bits", bus.out_bits, 0);
    check("rst cfg_busy", cfg_busy, 0);
    check("rst nrn", {na, nb, nc, nd, ne, nf}, 0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].kind == 1) idle_write(vecs[i].n, vecs[i].s, vecs[i].idx);
      if (vecs[i].kind == 2) model_write(vecs[i].n, vecs[i].s, vecs[i].idx);
      run_one(fdef, vecs[i].kind == 2, vecs[i].n, vecs[i].s, vecs[i].idx,
              vecs[i].exp, $sformatf("vec%0d", i));
    end

    // ---- write during RUN is dropped ----
    start_sample(fdef);
    step(); step();
    check("run busy", cfg_busy, 1);
    check("run in_ready", bus.in_ready, 0);
    cfg_we = 1'b1; cfg_neuron = 3'd0; cfg_slot = 3'd0; cfg_idx = 4'd7;
    step();
    cfg_we = 1'b0;
    wait_valid(4, t);
    check("rundrop latency", t, 10);
    check("rundrop bits", bus.out_bits, model_out(fdef));
    step();
    run_one(fdef, 0, 0, 0, 0, model_out(fdef), "rundrop next");

    // ---- HOLD stall with in_valid held high ----
    bus.out_ready = 1'b0;
    start_sample(fdef);
    wait_valid(1, t);
    check("hold latency", t, 10);
    f2 = feat_rand();
    bus.in_valid = 1'b1;
    bus.in_feat  = f2;
    base_hs = hs_q.size();
    for (int k = 0; k < 5; k++) begin
      check("hold out_valid", bus.out_valid, 1);
      check("hold bits", bus.out_bits, model_out(fdef));
      check("hold in_ready", bus.in_ready, 0);
      step();
    end
    check("hold no accept", hs_q.size(), base_hs);
    bus.out_ready = 1'b1;
    step();
    check("post hold in_ready", bus.in_ready, 1);
    check("post hold no accept yet", hs_q.size(), base_hs);
    step();
    bus.in_valid = 1'b0;
    check("post hold accepted", hs_q.size(), base_hs + 1);
    wait_valid(1, t);
    check("second latency", t, 10);
    check("second bits", bus.out_bits, model_out(f2));
    step();

    // ---- reset in the middle of RUN ----
    idle_write(3'd0, 3'd0, 4'd7);
    start_sample(fdef);
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst out_bits", bus.out_bits, 0);
    check("midrst nrn", {na, nb, nc, nd, ne, nf}, 0);
    check("midrst busy", cfg_busy, 0);
    model_reset();
    step();
    rst_n = 1'b1;
    cnt_v = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus.out_valid) cnt_v++;
      step();
    end
    check("midrst out_valid never", cnt_v, 0);
    run_one(fdef, 0, 0, 0, 0, 8'hF0, "after rst");

    // ---- back-to-back samples ----
    base_hs  = hs_q.size();
    base_out = out_q.size();
    for (int k = 0; k < 4; k++) fb[k] = feat_rand();
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_feat = fb[k];
      t = 0;
      while (!bus.in_ready && t < 30) begin
        step();
        t++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 14; k++) step();
    check("b2b hs count", hs_q.size(), base_hs + 4);
    check("b2b out count", out_q.size(), base_out + 4);
    if (hs_q.size() == base_hs + 4 && out_q.size() == base_out + 4) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) check($sformatf("b2b spacing%0d", k),
                         hs_q[base_hs + k] - hs_q[base_hs + k - 1], 11);
        check($sformatf("b2b bits%0d", k), out_q[base_out + k], model_out(fb[k]));
      end
    end

    // ---- randomized writes and samples vs model ----
    for (int k = 0; k < 16; k++) begin
      logic [2:0] rn, rs;
      logic [3:0] ri;
      bit same;
      rn = 3'($urandom_range(7, 0));
      rs = 3'($urandom_range(7, 0));
      ri = 4'($urandom_range(15, 0));
      same = ($urandom_range(1, 0) == 1);
      f2 = feat_rand();
      if (same) begin
        model_write(rn, rs, ri);
      end else begin
        idle_write(rn, rs, ri);
      end
      e2 = model_out(f2);
      run_one(f2, same, rn, rs, ri, e2, $sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tnn_neuron_scheduler.md
# tnn_neuron_scheduler

Time-multiplexes one shared combinational 6-input, 3-bit TNN neuron across `NUM_NEURONS` logical neurons of a layer. The block accepts one feature vector per handshake and routes six selected features per neuron from a programmable index table into the neuron operand ports. It collects the neuron's 1-bit decision for each neuron and returns the whole layer's output vector over a valid/ready handshake. It sits between the feature front-end and the class-vote stage.

## Interface
- `NUM_FEAT`, 11, features per sample, each 3 bits unsigned.
- `NUM_NEURONS`, 8, logical neurons served by the shared datapath.
- `IDX_W`, `$clog2(NUM_FEAT)`, width of a feature index.
- `NRN_W`, `$clog2(NUM_NEURONS)`, width of a neuron index.
- `clk`  in  1  clock; all state on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  feature vector valid.
- `in_ready`  out  1  block can accept a vector.
- `in_feat`  in  `NUM_FEAT*3`  feature i at bits `[3i+2:3i]`.
- `cfg_we`  in  1  index-table write strobe.
- `cfg_neuron`  in  `NRN_W`  neuron to configure.
- `cfg_slot`  in  3  operand slot 0..5 (a..f).
- `cfg_idx`  in  `IDX_W`  feature index for that slot.
- `cfg_busy`  out  1  high when not IDLE; writes are ignored while high.
- `nrn_a` … `nrn_f`  out  3 each  registered operands to the shared neuron.
- `nrn_out`  in  1  combinational neuron decision for the current operands.
- `out_valid`  out  1  `out_bits` valid.
- `out_ready`  in  1  consumer accepts `out_bits`.
- `out_bits`  out  `NUM_NEURONS`  bit n = decision of neuron n.

## Operation
- FSM has three states, IDLE / RUN / HOLD, plus a counter `cnt` with range 0..`NUM_NEURONS`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`, latch `in_feat` into the feature register, set `cnt`=0, and go to RUN.
- RUN:
  - Each cycle, operand registers load `feat[tbl[cnt][s]]` for slots s=0..5. This applies only when `cnt`<`NUM_NEURONS`; otherwise they hold.
  - If `cnt`≥1, capture `nrn_out` into `out_bits[cnt-1]`.
  - `cnt`++ each cycle. At `cnt`==`NUM_NEURONS`, perform the capture and then go to HOLD.
- HOLD:
  - `out_valid`=1, with `out_bits` stable.
  - On `out_ready`, go to IDLE.
  - `in_ready` stays 0 in HOLD; there is no overlap.
- Index table: `NUM_NEURONS`×6 entries of `IDX_W` bits.
  - Reset value: entry(n,s) = (n+s) mod `NUM_FEAT`.
  - A write takes effect only in IDLE with `cfg_slot`≤5 and `cfg_idx`<`NUM_FEAT`. Any other write is silently dropped.
  - A write in the same cycle as an input handshake is applied, and the new value is visible to that sample.
- `out_bits` are cleared to 0 on entering RUN.
- Reset, including mid-RUN or mid-HOLD, causes:
  - state IDLE, `cnt`=0;
  - `nrn_*`=0, `out_bits`=0, `out_valid`=0, `in_ready`=1 once `rst_n` is released;
  - the table returns to its default contents;
  - any in-flight sample is lost.

## Timing
- Handshake at cycle T0.
- RUN occupies T1..T(`NUM_NEURONS`+1).
- Operands for neuron k are visible at T(k+2) and captured at the end of T(k+2).
- `out_valid` rises at T(`NUM_NEURONS`+2), which is T10 for the defaults.
- Throughput is one sample per `NUM_NEURONS`+3 cycles with `out_ready` held high.
- The neuron path is single-cycle combinational from `nrn_*` registers to `nrn_out`. No pipelining of the neuron is permitted.
- `in_ready`, `cfg_busy` and `out_valid` are decoded from registered state only.

## Structure
- Package `tnn_sched_pkg` holds:
  - `FEAT_W`=3 and `NUM_SLOTS`=6;
  - `feat_t` (`logic [2:0]`);
  - the state enum `sched_state_e` {IDLE, RUN, HOLD};
  - the default-index function.
- Sub-module `tnn_sched_cfg_table`: register-file index table.
  - Write port with the legality checks.
  - Six combinational read ports addressed by neuron index.
- The shared neuron is instantiated outside this block and connected only through `nrn_*`/`nrn_out`.

## Test plan
Bench stub neuron: `nrn_out = nrn_a[2]`; `feat[i] = i mod 8`.
- Default table, one sample, `out_ready`=1 → `out_valid` at T10, `out_bits`=8'hF0, `in_ready` back to 1 at T11.
- Write neuron 0 slot 0 ← 7 in IDLE, then a sample → `out_bits`=8'hF1. Repeat the write during RUN → dropped, the next sample gives 8'hF1 again.
- Write `cfg_idx`=11 or `cfg_slot`=6 → table unchanged, `out_bits`=8'hF0.
- Hold `out_ready`=0 for 5 cycles in HOLD, with `in_valid`=1 throughout → `out_bits` stable, `in_ready`=0, no second sample accepted until the cycle after `out_ready`.
- Deassert `rst_n` at T4 of RUN → all outputs 0 immediately, `out_valid` never rises, and a fresh sample afterwards produces 8'hF0 at T10.
- Back-to-back samples with `out_ready`=1 → handshakes spaced exactly 11 cycles apart, each result correct.
